if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage plus IF/ID pipeline register. Owns the PC and issues
//   one-outstanding fetches to instruction memory over a req/rvalid handshake.
//   Presents {pc, instruction, valid} to decode, where the instruction feeds immgen,
//   control decode and the register file. Supports stall, flush and redirect.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC of the first fetch after reset; low 2 bits must be 0
//   NOP_INSTR 32'h0000_0013  Bubble encoding (addi x0,x0,0) driven on id_instr_o
// PORTS
//   clk            in   1   Clock. Rising edge.
//   rst_n          in   1   Reset. Asynchronous, active-low.
//   stall_i        in   1   Decode not ready. Hold IF/ID and the PC.
//   flush_i        in   1   Replace IF/ID contents with a bubble.
//   redirect_i     in   1   Taken branch/jump. Next fetch comes from redirect_pc_i.
//   redirect_pc_i  in   32  Redirect target. Bits [1:0] are forced to 0.
//   imem_req_o     out  1   Fetch request. One-cycle pulse. Memory always accepts it.
//   imem_addr_o    out  32  Fetch address. Valid while imem_req_o=1.
//   imem_rvalid_i  in   1   Response valid. Arrives >=1 cycle after the request.
//   imem_rdata_i   in   32  Fetched instruction. Valid while imem_rvalid_i=1.
//   id_valid_o     out  1   IF/ID holds a real instruction.
//   id_pc_o        out  32  PC of id_instr_o.
//   id_instr_o     out  32  Instruction to decode.
// BEHAVIOUR
//   Reset (async assert): id_valid_o=0, id_instr_o=NOP_INSTR, id_pc_o=RESET_PC,
//     imem_req_o=0, pc_q=RESET_PC, kill=0, skid empty, state=BOOT.
//   FSM states:
//     BOOT  Entered only through reset. Issue request to RESET_PC, then go to WAIT.
//     READY No fetch outstanding. Issue request to pc_q, then go to WAIT.
//     WAIT  One fetch outstanding for pc_q.
//     HOLD  Response captured in the skid buffer while stall_i=1. No fetch outstanding.
//   WAIT with rvalid, kill=0, stall=0:
//     IF/ID <= {1, pc_q, rdata}; pc_q <= pc_q+4.
//     In the same cycle, drive imem_req_o=1 with imem_addr_o=pc_q+4; stay in WAIT.
//     With 1-cycle memory latency, throughput is 1 instruction/cycle.
//   WAIT with rvalid, kill=0, stall=1: skid <= rdata; go to HOLD. IF/ID unchanged.
//   HOLD with stall=0: IF/ID <= {1, pc_q, skid}; pc_q += 4.
//     Issue the request to the new PC in the same cycle; go to WAIT.
//   WAIT with rvalid and kill=1: drop the response; kill <= 0.
//     Issue the request to pc_q in the same cycle.
//   Redirect has the highest priority and implies a flush:
//     pc_q <= {redirect_pc_i[31:2], 2'b00}; IF/ID <= bubble; skid discarded.
//     If in WAIT without rvalid: kill <= 1; stay in WAIT.
//     Otherwise, including WAIT with rvalid in the same cycle: drop any response; go to READY.
//     No request is issued in the redirect cycle itself.
//   flush_i without redirect: IF/ID <= {0, id_pc_o, NOP_INSTR}.
//     The fetch stream continues. flush overrides stall on IF/ID only.
//   Bubble value: valid=0, instr=NOP_INSTR, pc unchanged.
//   stall_i=1: IF/ID holds, and no new request is issued except the redirect path.
//   PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0.
//   Never more than one request outstanding.
//   rvalid in BOOT, READY or HOLD is a protocol error and is ignored.
// CONFIGURATION
//   IF_PERF_CNT_EN defined:
//     Adds out ports perf_fetch_o[31:0] and perf_stall_o[31:0].
//     perf_fetch_o counts IF/ID loads with valid=1.
//     perf_stall_o counts cycles with stall_i=1 && id_valid_o=1.
//     Both counters reset to 0 and wrap at 2^32.
//   IF_PERF_CNT_EN undefined: ports and counters are absent; behaviour is otherwise identical.
// TESTING
//   1. Release reset; memory at 1-cycle latency returns 0x00500093 at address 0:
//      req@0 on the first cycle; next cycle id={1,0x0,0x00500093} and req@4.
//   2. Streaming at 1-cycle latency with addresses 0,4,8,C:
//      id_valid stays 1 every cycle after the first; id_pc steps by 4.
//   3. stall_i=1 for 3 cycles while a response arrives:
//      IF/ID holds and there are no reqs. On release, id gets the skidded instruction; then req pc+4.
//   4. Redirect to 0x103 while a fetch is outstanding at 3-cycle latency:
//      the stale response is dropped, next req@0x100, and id_valid=0 until 0x100 returns.
//   5. flush_i and stall_i together: id_valid=0 and id_instr=0x00000013 next cycle.
//   6. Assert rst_n low mid-stream: outputs return to reset values immediately, without waiting for clk.
//      With IF_PERF_CNT_EN defined, perf_fetch_o=0 after reset and counts 4 after test 2.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, keeps one fetch in flight,
// and uses a one-entry skid buffer for stalls. Define IF_PERF_CNT_EN to add perf counters.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o
`ifdef IF_PERF_CNT_EN
   ,output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o
`endif
);

    typedef enum logic [1:0] {BOOT, READY, WAIT, HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] skid_q, skid_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;

    logic        req_c;
    logic [31:0] addr_c;
    logic        ld_c;
    logic [31:0] ld_instr_c;
    logic        bubble_c;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        skid_d     = skid_q;
        req_c      = 1'b0;
        addr_c     = pc_q;
        ld_c       = 1'b0;
        ld_instr_c = imem_rdata_i;
        bubble_c   = 1'b0;

        if (redirect_i) begin
            // A fetch still in flight must be killed when it returns; otherwise restart clean.
            pc_d     = redirect_pc_i & ~32'h3;
            bubble_c = 1'b1;
            if (state_q == WAIT && !imem_rvalid_i) begin
                kill_d = 1'b1;
            end else begin
                kill_d  = 1'b0;
                state_d = READY;
            end
        end else begin
            case (state_q)
                BOOT: begin
                    if (!stall_i) begin
                        req_c   = 1'b1;
                        addr_c  = RESET_PC;
                        state_d = WAIT;
                    end
                end
                READY: begin
                    if (!stall_i) begin
                        req_c   = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (kill_q) begin
                            kill_d = 1'b0;
                            req_c  = 1'b1;
                        end else if (stall_i) begin
                            skid_d  = imem_rdata_i;
                            state_d = HOLD;
                        end else begin
                            ld_c   = 1'b1;
                            pc_d   = pc_q + 32'd4;
                            req_c  = 1'b1;
                            addr_c = pc_q + 32'd4;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        ld_c       = 1'b1;
                        ld_instr_c = skid_q;
                        pc_d       = pc_q + 32'd4;
                        req_c      = 1'b1;
                        addr_c     = pc_q + 32'd4;
                        state_d    = WAIT;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    // Flush (or redirect) wins over both a load and a stall hold.
    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        if (bubble_c || flush_i) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (ld_c) begin
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_instr_d = ld_instr_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            skid_q     <= NOP_INSTR;
            id_valid_q <= 1'b0;
            id_pc_q    <= RESET_PC;
            id_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            skid_q     <= skid_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    // BOOT requests combinationally, so mask the request while reset is held.
    assign imem_req_o  = req_c & rst_n;
    assign imem_addr_o = addr_c;
    assign id_valid_o  = id_valid_q;
    assign id_pc_o     = id_pc_q;
    assign id_instr_o  = id_instr_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (ld_c && !bubble_c && !flush_i) perf_fetch_q <= perf_fetch_q + 32'd1;
            if (stall_i && id_valid_q)         perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: boot, streaming, stall/skid, redirect with kill,
// flush+stall, async reset and PC wrap, against a simple latency-programmable memory.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o, id_instr_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_o, perf_stall_o;
`endif

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_instr_o    (id_instr_o)
`ifdef IF_PERF_CNT_EN
       ,.perf_fetch_o  (perf_fetch_o),
        .perf_stall_o  (perf_stall_o)
`endif
    );

    always #5 clk = ~clk;

    // Instruction image: address 0 holds 0x00500093, other words are address-tagged.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[23:0], 8'h00};
    endfunction

    // Memory: response appears 'lat' cycles after the request cycle.
    int          lat;
    int          cnt;
    logic [31:0] maddr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 0;
            maddr <= 32'd0;
        end else if (imem_req_o) begin
            cnt   <= lat;
            maddr <= imem_addr_o;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end
    end
    assign imem_rvalid_i = (cnt == 1);
    assign imem_rdata_i  = imem_rvalid_i ? mem_word(maddr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = 32'd0; lat = 1;
        repeat (2) cyc();
        #1;
        chk("rst_valid", {31'd0, id_valid_o}, 32'd0);
        chk("rst_instr", id_instr_o, 32'h13);
        chk("rst_pc",    id_pc_o, 32'd0);
        chk("rst_req",   {31'd0, imem_req_o}, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("rst_perf_fetch", perf_fetch_o, 32'd0);
`endif
        // Boot and streaming at 1-cycle latency
        rst_n = 1'b1; #1;
        chk("boot_req",  {31'd0, imem_req_o}, 32'd1);
        chk("boot_addr", imem_addr_o, 32'd0);
        cyc(); #1;
        chk("c1_req",    {31'd0, imem_req_o}, 32'd1);
        chk("c1_addr",   imem_addr_o, 32'd4);
        chk("c1_valid",  {31'd0, id_valid_o}, 32'd0);
        cyc(); #1;
        chk("c2_valid",  {31'd0, id_valid_o}, 32'd1);
        chk("c2_pc",     id_pc_o, 32'd0);
        chk("c2_instr",  id_instr_o, 32'h0050_0093);
        chk("c2_addr",   imem_addr_o, 32'd8);
        cyc(); #1;
        chk("c3_valid",  {31'd0, id_valid_o}, 32'd1);
        chk("c3_pc",     id_pc_o, 32'd4);
        chk("c3_instr",  id_instr_o, mem_word(32'd4));
        cyc(); #1;
        chk("c4_valid",  {31'd0, id_valid_o}, 32'd1);
        chk("c4_pc",     id_pc_o, 32'd8);
        // Stall three cycles while the 0x10 response arrives
        cyc(); stall_i = 1'b1; #1;
        chk("c5_pc",     id_pc_o, 32'hC);
        chk("c5_valid",  {31'd0, id_valid_o}, 32'd1);
        chk("c5_req",    {31'd0, imem_req_o}, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch_4", perf_fetch_o, 32'd4);
`endif
        cyc(); #1;
        chk("c6_req",    {31'd0, imem_req_o}, 32'd0);
        chk("c6_pc",     id_pc_o, 32'hC);
        cyc(); #1;
        chk("c7_req",    {31'd0, imem_req_o}, 32'd0);
        chk("c7_pc",     id_pc_o, 32'hC);
        cyc(); stall_i = 1'b0; #1;
        chk("c8_req",    {31'd0, imem_req_o}, 32'd1);
        chk("c8_addr",   imem_addr_o, 32'h14);
        chk("c8_pc",     id_pc_o, 32'hC);
`ifdef IF_PERF_CNT_EN
        chk("perf_stall_3", perf_stall_o, 32'd3);
`endif
        cyc(); lat = 3; #1;
        chk("c9_pc",     id_pc_o, 32'h10);
        chk("c9_instr",  id_instr_o, mem_word(32'h10));
        chk("c9_addr",   imem_addr_o, 32'h18);
        // Redirect to 0x103 with the 0x18 fetch in flight at 3-cycle latency
        cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h103; #1;
        chk("c10_req",   {31'd0, imem_req_o}, 32'd0);
        chk("c10_pc",    id_pc_o, 32'h14);
        chk("c10_valid", {31'd0, id_valid_o}, 32'd1);
        cyc(); redirect_i = 1'b0; #1;
        chk("c11_valid", {31'd0, id_valid_o}, 32'd0);
        chk("c11_pc",    id_pc_o, 32'h14);
        chk("c11_instr", id_instr_o, 32'h13);
        chk("c11_req",   {31'd0, imem_req_o}, 32'd0);
        cyc(); #1;
        chk("c12_req",   {31'd0, imem_req_o}, 32'd1);
        chk("c12_addr",  imem_addr_o, 32'h100);
        chk("c12_valid", {31'd0, id_valid_o}, 32'd0);
        cyc(); #1;
        chk("c13_req",   {31'd0, imem_req_o}, 32'd0);
        chk("c13_valid", {31'd0, id_valid_o}, 32'd0);
        cyc(); lat = 1; #1;
        chk("c14_valid", {31'd0, id_valid_o}, 32'd0);
        cyc(); #1;
        chk("c15_req",   {31'd0, imem_req_o}, 32'd1);
        chk("c15_addr",  imem_addr_o, 32'h104);
        chk("c15_valid", {31'd0, id_valid_o}, 32'd0);
        cyc(); #1;
        chk("c16_valid", {31'd0, id_valid_o}, 32'd1);
        chk("c16_pc",    id_pc_o, 32'h100);
        chk("c16_instr", id_instr_o, mem_word(32'h100));
        // Flush and stall together
        stall_i = 1'b1; flush_i = 1'b1; #1;
        chk("c16_req",   {31'd0, imem_req_o}, 32'd0);
        cyc(); stall_i = 1'b0; flush_i = 1'b0; #1;
        chk("c17_valid", {31'd0, id_valid_o}, 32'd0);
        chk("c17_instr", id_instr_o, 32'h13);
        chk("c17_pc",    id_pc_o, 32'h100);
        chk("c17_addr",  imem_addr_o, 32'h108);
        cyc(); #1;
        chk("c18_pc",    id_pc_o, 32'h104);
        chk("c18_instr", id_instr_o, mem_word(32'h104));
        // Asynchronous reset mid-stream, checked before the next clock edge
        #2 rst_n = 1'b0; #1;
        chk("arst_valid", {31'd0, id_valid_o}, 32'd0);
        chk("arst_instr", id_instr_o, 32'h13);
        chk("arst_pc",    id_pc_o, 32'd0);
        chk("arst_req",   {31'd0, imem_req_o}, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("arst_perf_fetch", perf_fetch_o, 32'd0);
`endif
        // Reboot, redirect to 0xFFFFFFFF (aligned down) and wrap the PC
        cyc(); rst_n = 1'b1; #1;
        chk("reboot_req",  {31'd0, imem_req_o}, 32'd1);
        chk("reboot_addr", imem_addr_o, 32'd0);
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF; #1;
        chk("redir_noreq", {31'd0, imem_req_o}, 32'd0);
        cyc(); redirect_i = 1'b0; #1;
        chk("w1_req",    {31'd0, imem_req_o}, 32'd1);
        chk("w1_addr",   imem_addr_o, 32'hFFFF_FFFC);
        cyc(); #1;
        chk("wrap_addr", imem_addr_o, 32'd0);
        chk("wrap_req",  {31'd0, imem_req_o}, 32'd1);
        cyc(); #1;
        chk("w3_valid",  {31'd0, id_valid_o}, 32'd1);
        chk("w3_pc",     id_pc_o, 32'hFFFF_FFFC);
        chk("w3_instr",  id_instr_o, mem_word(32'hFFFF_FFFC));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
